// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_if
// Brief    : Register-slave handshake bundle for the interrupt controller.
// Revision : 1.0
// ============================================================================
interface irq_ctrl_if;
  logic        reg_valid_i;
  logic [7:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic [31:0] reg_rdata_o;
  logic        reg_ready_o;

  modport master (
    output reg_valid_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_rdata_o, reg_ready_o
  );

  modport slave (
    input  reg_valid_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_rdata_o, reg_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : Edge/level interrupt controller with W1C pending and claim register.
// Revision : 1.0
// ============================================================================
module irq_ctrl #(
  parameter int NUM_IRQ = 32,
  parameter bit SYNC_EN = 1'b1
) (
  input  wire                clk_i,
  input  wire                rst_n_i,
  input  wire  [NUM_IRQ-1:0] irq_src_i,
  irq_ctrl_if.slave          bus,
  output logic [31:0]        irq_o,
  output logic               irq_any_o
);

  localparam logic [31:0] c_IMPL = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << NUM_IRQ) - 32'd1);
  localparam logic [5:0] c_IDX_PEND  = 6'd0;
  localparam logic [5:0] c_IDX_ENA   = 6'd1;
  localparam logic [5:0] c_IDX_TYPE  = 6'd2;
  localparam logic [5:0] c_IDX_POL   = 6'd3;
  localparam logic [5:0] c_IDX_CLAIM = 6'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [31:0] r_pend;
  logic [31:0] r_prev;
  logic [31:0] r_ena;
  logic [31:0] r_type;
  logic [31:0] r_pol;
  logic [31:0] r_irq;
  logic        r_irq_any;

  logic [31:0] w_src;
  logic [31:0] w_s;
  logic [31:0] w_rise;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic [5:0]  w_idx;
  logic [31:0] w_wmask;
  logic [31:0] w_pe;
  logic        w_claim_hit;
  logic [4:0]  w_claim_id;
  logic [31:0] w_claim_val;
  logic [31:0] w_claim_clr;
  logic [31:0] w_w1c;
  logic [31:0] w_pend_nxt;
  logic [31:0] w_rdval;
  logic        w_unused;

  generate
    if (SYNC_EN) begin : g_sync
      logic [NUM_IRQ-1:0] r_meta;
      logic [NUM_IRQ-1:0] r_sync;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_meta <= '0;
          r_sync <= '0;
        end else begin
          r_meta <= irq_src_i;
          r_sync <= r_meta;
        end
      end
      assign w_src = 32'(r_sync);
    end else begin : g_nosync
      assign w_src = 32'(irq_src_i);
    end
  endgenerate

  assign w_s    = (w_src ^ r_pol) & c_IMPL;
  assign w_rise = w_s & ~r_prev;

  assign w_accept = (r_state == ST_IDLE) && bus.reg_valid_i && !r_ready;
  assign w_wr     = w_accept && (bus.reg_wstrb_i != 4'b0000);
  assign w_rd     = w_accept && (bus.reg_wstrb_i == 4'b0000);
  assign w_idx    = bus.reg_addr_i[7:2];
  assign w_wmask  = {{8{bus.reg_wstrb_i[3]}}, {8{bus.reg_wstrb_i[2]}},
                     {8{bus.reg_wstrb_i[1]}}, {8{bus.reg_wstrb_i[0]}}} & c_IMPL;
  assign w_unused = ^bus.reg_addr_i[1:0];

  assign w_pe = r_pend & r_ena;

  // Scan downwards so the last hit is the lowest active id.
  always_comb begin
    w_claim_hit = 1'b0;
    w_claim_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pe[i]) begin
        w_claim_hit = 1'b1;
        w_claim_id  = 5'(i);
      end
    end
  end

  assign w_claim_val = w_claim_hit ? {26'd0, {1'b0, w_claim_id} + 6'd1} : 32'd0;
  assign w_claim_clr = (w_rd && (w_idx == c_IDX_CLAIM) && w_claim_hit)
                     ? (32'd1 << w_claim_id) : 32'd0;
  assign w_w1c       = (w_wr && (w_idx == c_IDX_PEND))
                     ? (bus.reg_wdata_i & w_wmask) : 32'd0;

  // Edge sources: a new edge beats any clear in the same cycle.
  assign w_pend_nxt = ((r_type & ((r_pend & ~(w_w1c | w_claim_clr)) | w_rise))
                    | (~r_type & w_s)) & c_IMPL;

  always_comb begin
    w_rdval = '0;
    case (w_idx)
      c_IDX_PEND:  w_rdval = r_pend;
      c_IDX_ENA:   w_rdval = r_ena;
      c_IDX_TYPE:  w_rdval = r_type;
      c_IDX_POL:   w_rdval = r_pol;
      c_IDX_CLAIM: w_rdval = w_claim_val;
      default:     w_rdval = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend    <= '0;
      r_prev    <= '0;
      r_ena     <= '0;
      r_type    <= '0;
      r_pol     <= '0;
      r_irq     <= '0;
      r_irq_any <= 1'b0;
    end else begin
      r_prev <= w_s;
      r_pend <= w_pend_nxt;
      if (w_wr && (w_idx == c_IDX_ENA))
        r_ena <= (r_ena & ~w_wmask) | (bus.reg_wdata_i & w_wmask);
      if (w_wr && (w_idx == c_IDX_TYPE))
        r_type <= (r_type & ~w_wmask) | (bus.reg_wdata_i & w_wmask);
      if (w_wr && (w_idx == c_IDX_POL))
        r_pol <= (r_pol & ~w_wmask) | (bus.reg_wdata_i & w_wmask);
      r_irq     <= r_pend & r_ena;
      r_irq_any <= |(r_pend & r_ena);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_state <= ST_ACK;
          r_ready <= 1'b1;
          r_rdata <= w_rd ? w_rdval : 32'd0;
        end
      end else begin
        r_state <= ST_IDLE;
        r_ready <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  assign bus.reg_ready_o = r_ready;
  assign bus.reg_rdata_o = r_rdata;
  assign irq_o           = r_irq;
  assign irq_any_o       = r_irq_any;

endmodule
`default_nettype wire
